// File: rtl/mux_sel_serializer.sv
// rtl/mux_sel_serializer.sv - byte-to-bit serializer driving an external 8:1 bit-select mux
// Holds the accepted byte on mux_in, steps mux_sel, streams mux_out with optional parity and idle gap.
module mux_sel_serializer #(
  parameter int GAP_CYCLES = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_msb_first,
  input  logic       s_parity_en,
  output logic [7:0] mux_in,
  output logic [2:0] mux_sel,
  input  logic       mux_out,
  output logic       ser_valid,
  input  logic       ser_ready,
  output logic       ser_bit,
  output logic       ser_first,
  output logic       ser_last,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;

  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam logic       PAR_INIT = 1'(PARITY_ODD);

  state_t     state, state_nxt;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic       par_acc;
  logic [3:0] gap_cnt;
  logic       msb_first_q;
  logic       parity_en_q;
  logic       xfer;

  assign idx_nxt = idx + 3'd1;
  assign xfer    = ser_valid && ser_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (s_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (ser_ready && idx == 3'd7) begin
          if (parity_en_q)         state_nxt = PARITY;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
          else                     state_nxt = IDLE;
        end
      end
      PARITY: begin
        if (ser_ready) state_nxt = (GAP_CYCLES > 0) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    s_ready   = (state == IDLE);
    busy      = (state != IDLE);
    ser_valid = (state == SHIFT) || (state == PARITY);
    ser_bit   = (state == SHIFT) ? mux_out : par_acc;
    ser_first = (state == SHIFT) && (idx == 3'd0);
    ser_last  = ((state == SHIFT) && (idx == 3'd7) && !parity_en_q) || (state == PARITY);
  end

  // 7 - n in three bits is the bitwise inverse, so msb-first walks 7..0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mux_in      <= 8'd0;
      mux_sel     <= 3'd0;
      idx         <= 3'd0;
      par_acc     <= 1'b0;
      gap_cnt     <= 4'd0;
      msb_first_q <= 1'b0;
      parity_en_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_valid) begin
            mux_in      <= s_data;
            msb_first_q <= s_msb_first;
            parity_en_q <= s_parity_en;
            idx         <= 3'd0;
            par_acc     <= PAR_INIT;
            mux_sel     <= s_msb_first ? 3'd7 : 3'd0;
          end
        end
        SHIFT: begin
          if (xfer) begin
            par_acc <= par_acc ^ mux_out;
            idx     <= idx_nxt;
            if (idx != 3'd7) mux_sel <= msb_first_q ? ~idx_nxt : idx_nxt;
          end
        end
        GAP: begin
          if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
        end
        default: ;
      endcase
      if (state_nxt == GAP && state != GAP) gap_cnt <= GAP_LOAD;
    end
  end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// tb/tb_mux_sel_serializer.sv - scoreboard bench for mux_sel_serializer
// Two instances: a (GAP_CYCLES=3, even parity) and b (GAP_CYCLES=0, odd parity).
module tb_mux_sel_serializer;

  typedef struct packed {
    logic       b;
    logic       f;
    logic       l;
    logic [2:0] s;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_valid_a, s_valid_b;
  logic [7:0] s_data;
  logic       s_msb_first, s_parity_en, ser_ready;

  logic       s_ready_a, ser_valid_a, ser_bit_a, ser_first_a, ser_last_a, busy_a, mux_out_a;
  logic [7:0] mux_in_a;
  logic [2:0] mux_sel_a;
  logic       s_ready_b, ser_valid_b, ser_bit_b, ser_first_b, ser_last_b, busy_b, mux_out_b;
  logic [7:0] mux_in_b;
  logic [2:0] mux_sel_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  assign mux_out_a = mux_in_a[mux_sel_a];
  assign mux_out_b = mux_in_b[mux_sel_b];

  mux_sel_serializer #(.GAP_CYCLES(3), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_a), .s_ready(s_ready_a), .s_data(s_data),
    .s_msb_first(s_msb_first), .s_parity_en(s_parity_en), .mux_in(mux_in_a), .mux_sel(mux_sel_a),
    .mux_out(mux_out_a), .ser_valid(ser_valid_a), .ser_ready(ser_ready), .ser_bit(ser_bit_a),
    .ser_first(ser_first_a), .ser_last(ser_last_a), .busy(busy_a)
  );

  mux_sel_serializer #(.GAP_CYCLES(0), .PARITY_ODD(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid_b), .s_ready(s_ready_b), .s_data(s_data),
    .s_msb_first(s_msb_first), .s_parity_en(s_parity_en), .mux_in(mux_in_b), .mux_sel(mux_sel_b),
    .mux_out(mux_out_b), .ser_valid(ser_valid_b), .ser_ready(ser_ready), .ser_bit(ser_bit_b),
    .ser_first(ser_first_b), .ser_last(ser_last_b), .busy(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Peek the head while stalled (stability), pop on transfer.
  always @(negedge clk) begin
    if (rst_n && ser_valid_a) begin
      if (qa.size() == 0) check("a_extra_bit", 1, 0);
      else begin
        check("a_bit", ser_bit_a, qa[0].b);
        check("a_first", ser_first_a, qa[0].f);
        check("a_last", ser_last_a, qa[0].l);
        check("a_sel", mux_sel_a, qa[0].s);
        if (ser_ready) void'(qa.pop_front());
      end
    end
    if (rst_n && ser_valid_b) begin
      if (qb.size() == 0) check("b_extra_bit", 1, 0);
      else begin
        check("b_bit", ser_bit_b, qb[0].b);
        check("b_first", ser_first_b, qb[0].f);
        check("b_last", ser_last_b, qb[0].l);
        check("b_sel", mux_sel_b, qb[0].s);
        if (ser_ready) void'(qb.pop_front());
      end
    end
  end

  function automatic int qsize(input int inst);
    return (inst == 0) ? qa.size() : qb.size();
  endfunction

  task automatic push_frame(input int inst, input logic [7:0] d, input logic m, input logic p);
    exp_t       e;
    logic       odd;
    logic [2:0] s;
    odd = (inst == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < 8; i++) begin
      s   = m ? 3'(7 - i) : 3'(i);
      e.s = s;
      e.b = d[s];
      e.f = (i == 0);
      e.l = (i == 7) && !p;
      if (inst == 0) qa.push_back(e); else qb.push_back(e);
    end
    if (p) begin
      e.s = m ? 3'd0 : 3'd7;
      e.b = odd ^ (^d);
      e.f = 1'b0;
      e.l = 1'b1;
      if (inst == 0) qa.push_back(e); else qb.push_back(e);
    end
  endtask

  // Called #1 after a posedge; returns #1 after the accepting edge.
  task automatic accept_frame(input int inst, input logic [7:0] d, input logic m, input logic p,
                              input bit hold, output int waits);
    s_data = d; s_msb_first = m; s_parity_en = p;
    if (inst == 0) s_valid_a = 1'b1; else s_valid_b = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      if ((inst == 0) ? s_ready_a : s_ready_b) break;
      waits++;
      if (waits > 50) begin
        check("accept_timeout", 1, 0);
        break;
      end
    end
    push_frame(inst, d, m, p);
    @(posedge clk); #1;
    if (!hold) begin
      s_valid_a = 1'b0; s_valid_b = 1'b0;
    end
    check("first_bit_latency", (inst == 0) ? ser_valid_a : ser_valid_b, 1);
  endtask

  task automatic drain(input int inst, input bit stall, input int exp_cycles);
    int cyc;
    logic [3:0] pat;
    pat = 4'b1001;
    cyc = 0;
    while (qsize(inst) > 0 && cyc < 200) begin
      ser_ready = stall ? pat[cyc % 4] : 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    ser_ready = 1'b1;
    if (qsize(inst) > 0) check("drain_timeout", qsize(inst), 0);
    if (exp_cycles >= 0) check("drain_cycles", cyc, exp_cycles);
  endtask

  initial begin
    int w;
    logic [7:0] rd;
    logic rm, rp, rs;
    rst_n = 1'b0; s_valid_a = 1'b0; s_valid_b = 1'b0;
    s_data = 8'h00; s_msb_first = 1'b0; s_parity_en = 1'b0; ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_ready_a, 1);
    check("rst_ser_valid", ser_valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_mux_sel", mux_sel_a, 0);
    check("rst_mux_in", mux_in_a, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // B4 lsb-first, then a held second byte across the 3-cycle gap.
    accept_frame(0, 8'hB4, 1'b0, 1'b0, 1'b1, w);
    s_data = 8'h5A; s_msb_first = 1'b1; s_parity_en = 1'b1;
    drain(0, 1'b0, 8);
    for (int g = 0; g < 3; g++) begin
      check("gap_s_ready", s_ready_a, 0);
      check("gap_busy", busy_a, 1);
      @(posedge clk); #1;
    end
    check("gap_end_ready", s_ready_a, 1);
    accept_frame(0, 8'hB4, 1'b1, 1'b1, 1'b0, w);
    check("gap_accept_wait", w, 0);
    drain(0, 1'b0, 9);

    // Same frame under a 1,0,0,1 ready pattern.
    accept_frame(0, 8'hB4, 1'b1, 1'b1, 1'b0, w);
    drain(0, 1'b1, -1);

    // Odd parity, no gap: back-to-back with no wait.
    accept_frame(1, 8'hFF, 1'b0, 1'b1, 1'b0, w);
    drain(1, 1'b0, 9);
    accept_frame(1, 8'h00, 1'b1, 1'b1, 1'b0, w);
    check("b2b_wait", w, 0);
    drain(1, 1'b0, 9);

    // Asynchronous reset at idx 4.
    accept_frame(0, 8'hA5, 1'b0, 1'b0, 1'b0, w);
    repeat (4) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    check("arst_ser_valid", ser_valid_a, 0);
    check("arst_s_ready", s_ready_a, 1);
    check("arst_busy", busy_a, 0);
    check("arst_mux_sel", mux_sel_a, 0);
    check("arst_mux_in", mux_in_a, 0);
    qa.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_ready", s_ready_a, 1);
    accept_frame(0, 8'h01, 1'b0, 1'b0, 1'b0, w);
    drain(0, 1'b0, 8);

    for (int k = 0; k < 6; k++) begin
      rd = 8'($urandom_range(0, 255));
      rm = 1'($urandom_range(0, 1));
      rp = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      accept_frame(1, rd, rm, rp, 1'b0, w);
      drain(1, rs, rs ? -1 : (8 + int'(rp)));
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
